// File: rtl/stream_demux_1to4.sv
// Registered 1-to-4 stream distributor: steers each accepted input beat into one
// of four one-entry lane registers, chosen by an explicit select or a round-robin pointer.
module stream_demux_1to4 #(
  parameter int DataWidth = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [1:0]           sel,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DataWidth-1:0] s_data,
  input  logic                 s_last,
  output logic [3:0]           m_valid,
  input  logic [3:0]           m_ready,
  output logic [DataWidth-1:0] m_data_0,
  output logic [DataWidth-1:0] m_data_1,
  output logic [DataWidth-1:0] m_data_2,
  output logic [DataWidth-1:0] m_data_3,
  output logic [1:0]           rr_ptr
);

  logic [1:0]           target;
  logic                 accept;
  logic [3:0]           load;
  logic [DataWidth-1:0] lane_data [4];

  // Readiness looks only at the targeted lane, so a stalled lane never blocks the others.
  assign target  = mode ? rr_ptr : sel;
  assign s_ready = !m_valid[target] || m_ready[target];
  assign accept  = s_valid && s_ready;

  always_comb begin
    load = 4'b0000;
    if (accept) load[target] = 1'b1;
  end

  // NOTE: all state below uses non-blocking assignments so every lane samples
  // pre-edge values; the small lane registers are reset because the reset
  // contract makes their contents visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 4'b0000;
      rr_ptr  <= 2'd0;
      for (int i = 0; i < 4; i++) lane_data[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        // A load on the same edge as a drain wins, sustaining one beat per cycle.
        if (load[i]) begin
          m_valid[i]   <= 1'b1;
          lane_data[i] <= s_data;
        end else if (m_ready[i]) begin
          m_valid[i] <= 1'b0;
        end
      end
      if (accept && mode) rr_ptr <= s_last ? 2'd0 : rr_ptr + 2'd1;
    end
  end

  assign m_data_0 = lane_data[0];
  assign m_data_1 = lane_data[1];
  assign m_data_2 = lane_data[2];
  assign m_data_3 = lane_data[3];

endmodule

// File: tb/tb_stream_demux_1to4.sv
// Directed testbench for stream_demux_1to4: one task per scenario, inline
// comparisons against hand-computed expectations, one summary line at the end.
module tb_stream_demux_1to4;

  logic       clk;
  logic       rst;
  logic       mode;
  logic [1:0] sel;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic [3:0] m_valid;
  logic [3:0] m_ready;
  logic [7:0] m_data_0, m_data_1, m_data_2, m_data_3;
  logic [1:0] rr_ptr;

  int vectors     = 0;
  int miscompares = 0;

  stream_demux_1to4 #(.DataWidth(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data_0(m_data_0), .m_data_1(m_data_1), .m_data_2(m_data_2), .m_data_3(m_data_3),
    .rr_ptr(rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lane_data(input int idx);
    case (idx)
      0:       return m_data_0;
      1:       return m_data_1;
      2:       return m_data_2;
      default: return m_data_3;
    endcase
  endfunction

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic md, input logic [1:0] sl,
                       input logic [7:0] d, input logic lst);
    s_valid = v;
    mode    = md;
    sel     = sl;
    s_data  = d;
    s_last  = lst;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (m_valid !== 4'b0000) begin
      miscompares++; $display("FAIL reset_m_valid: got %b expected 0000", m_valid);
    end
    vectors++;
    if ({m_data_0, m_data_1, m_data_2, m_data_3} !== 32'h0) begin
      miscompares++; $display("FAIL reset_m_data: got %h %h %h %h expected all 00",
                              m_data_0, m_data_1, m_data_2, m_data_3);
    end
    vectors++;
    if (rr_ptr !== 2'd0) begin
      miscompares++; $display("FAIL reset_rr_ptr: got %0d expected 0", rr_ptr);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_select();
    m_ready = 4'b1111;
    drive(1'b1, 1'b0, 2'd2, 8'hA5, 1'b0);
    #1;
    vectors++;
    if (s_ready !== 1'b1) begin
      miscompares++; $display("FAIL sel_s_ready: got %b expected 1", s_ready);
    end
    tick();
    drive(1'b0, 1'b0, 2'd2, 8'h00, 1'b0);
    vectors++;
    if (m_valid !== 4'b0100 || m_data_2 !== 8'hA5) begin
      miscompares++; $display("FAIL sel_load: got m_valid=%b m_data_2=%h expected 0100 a5",
                              m_valid, m_data_2);
    end
    tick();
    vectors++;
    if (m_valid !== 4'b0000 || m_data_2 !== 8'hA5 || rr_ptr !== 2'd0) begin
      miscompares++; $display("FAIL sel_drain: got m_valid=%b m_data_2=%h rr_ptr=%0d expected 0000 a5 0",
                              m_valid, m_data_2, rr_ptr);
    end
  endtask

  task automatic test_backpressure();
    m_ready = 4'b1101;
    drive(1'b1, 1'b0, 2'd1, 8'h11, 1'b0);
    tick();
    vectors++;
    if (m_valid !== 4'b0010 || m_data_1 !== 8'h11) begin
      miscompares++; $display("FAIL bp_first: got m_valid=%b m_data_1=%h expected 0010 11",
                              m_valid, m_data_1);
    end
    drive(1'b1, 1'b0, 2'd1, 8'h22, 1'b0);
    #1;
    vectors++;
    if (s_ready !== 1'b0) begin
      miscompares++; $display("FAIL bp_blocked_ready: got %b expected 0", s_ready);
    end
    tick();
    vectors++;
    if (m_valid !== 4'b0010 || m_data_1 !== 8'h11) begin
      miscompares++; $display("FAIL bp_hold: got m_valid=%b m_data_1=%h expected 0010 11",
                              m_valid, m_data_1);
    end
    drive(1'b1, 1'b0, 2'd3, 8'h33, 1'b0);
    #1;
    vectors++;
    if (s_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_other_lane_ready: got %b expected 1", s_ready);
    end
    tick();
    drive(1'b0, 1'b0, 2'd1, 8'h22, 1'b0);
    vectors++;
    if (m_valid !== 4'b1010 || m_data_3 !== 8'h33 || m_data_1 !== 8'h11) begin
      miscompares++; $display("FAIL bp_lane3: got m_valid=%b m_data_3=%h m_data_1=%h expected 1010 33 11",
                              m_valid, m_data_3, m_data_1);
    end
    m_ready = 4'b1111;
    tick();
    vectors++;
    if (m_valid !== 4'b0000) begin
      miscompares++; $display("FAIL bp_drain: got m_valid=%b expected 0000", m_valid);
    end
    drive(1'b1, 1'b0, 2'd1, 8'h22, 1'b0);
    tick();
    drive(1'b0, 1'b0, 2'd1, 8'h00, 1'b0);
    vectors++;
    if (m_valid !== 4'b0010 || m_data_1 !== 8'h22) begin
      miscompares++; $display("FAIL bp_retry: got m_valid=%b m_data_1=%h expected 0010 22",
                              m_valid, m_data_1);
    end
    tick();
  endtask

  task automatic test_round_robin();
    m_ready = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      logic [3:0] exp_valid;
      exp_valid = 4'b0001 << (i % 4);
      drive(1'b1, 1'b1, 2'd0, 8'h10 + 8'(i), 1'b0);
      #1;
      vectors++;
      if (s_ready !== 1'b1 || rr_ptr !== 2'(i % 4)) begin
        miscompares++; $display("FAIL rr_pre_%0d: got s_ready=%b rr_ptr=%0d expected 1 %0d",
                                i, s_ready, rr_ptr, i % 4);
      end
      tick();
      vectors++;
      if (m_valid !== exp_valid || lane_data(i % 4) !== 8'h10 + 8'(i)) begin
        miscompares++; $display("FAIL rr_beat_%0d: got m_valid=%b data=%h expected %b %h",
                                i, m_valid, lane_data(i % 4), exp_valid, 8'h10 + 8'(i));
      end
    end
    drive(1'b0, 1'b1, 2'd0, 8'h00, 1'b0);
    vectors++;
    if (rr_ptr !== 2'd2) begin
      miscompares++; $display("FAIL rr_final_ptr: got %0d expected 2", rr_ptr);
    end
    tick();
  endtask

  task automatic test_last();
    logic [7:0] beats [5] = '{8'h3F, 8'h40, 8'h41, 8'h42, 8'h43};
    logic       lasts [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int         lanes [5] = '{2, 0, 1, 2, 0};
    logic [1:0] ptrs  [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    m_ready = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 2'd3, beats[i], lasts[i]);
      tick();
      vectors++;
      if (m_valid !== (4'b0001 << lanes[i]) || lane_data(lanes[i]) !== beats[i] || rr_ptr !== ptrs[i]) begin
        miscompares++; $display("FAIL last_beat_%0d: got m_valid=%b data=%h rr_ptr=%0d expected lane %0d %h %0d",
                                i, m_valid, lane_data(lanes[i]), rr_ptr, lanes[i], beats[i], ptrs[i]);
      end
    end
    // Select mode must neither move nor clear the pointer, even with s_last set.
    drive(1'b1, 1'b0, 2'd3, 8'h55, 1'b1);
    tick();
    drive(1'b0, 1'b0, 2'd3, 8'h00, 1'b0);
    vectors++;
    if (m_valid !== 4'b1000 || m_data_3 !== 8'h55 || rr_ptr !== 2'd1) begin
      miscompares++; $display("FAIL last_mode0_hold: got m_valid=%b m_data_3=%h rr_ptr=%0d expected 1000 55 1",
                              m_valid, m_data_3, rr_ptr);
    end
    tick();
  endtask

  task automatic test_throughput();
    logic [7:0] received [$];
    int sent   = 0;
    int stalls = 0;
    int cyc    = 0;
    while (received.size() < 10 && cyc < 40) begin
      m_ready = {3'b111, (cyc != 5)};
      drive(sent < 10, 1'b0, 2'd0, 8'h80 + 8'(sent), 1'b0);
      #1;
      if (m_valid[0] && m_ready[0]) received.push_back(m_data_0);
      if (s_valid && !s_ready) stalls++;
      if (s_valid && s_ready) sent++;
      tick();
      cyc++;
    end
    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    m_ready = 4'b1111;
    vectors++;
    if (received.size() != 10) begin
      miscompares++; $display("FAIL tp_count: got %0d beats expected 10 within budget", received.size());
    end
    for (int k = 0; k < received.size(); k++) begin
      vectors++;
      if (received[k] !== 8'h80 + 8'(k)) begin
        miscompares++; $display("FAIL tp_order_%0d: got %h expected %h", k, received[k], 8'h80 + 8'(k));
      end
    end
    vectors++;
    if (stalls != 1) begin
      miscompares++; $display("FAIL tp_stalls: got %0d stall cycles expected 1", stalls);
    end
    tick();
  endtask

  task automatic test_async_reset();
    m_ready = 4'b1111;
    drive(1'b1, 1'b1, 2'd0, 8'hB1, 1'b0);
    tick();
    drive(1'b1, 1'b1, 2'd0, 8'hB2, 1'b0);
    tick();
    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    tick();
    m_ready = 4'b0000;
    drive(1'b1, 1'b0, 2'd0, 8'hC0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 2'd1, 8'hC1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 2'd3, 8'hC3, 1'b0);
    tick();
    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    vectors++;
    if (m_valid !== 4'b1011 || rr_ptr !== 2'd3) begin
      miscompares++; $display("FAIL ar_setup: got m_valid=%b rr_ptr=%0d expected 1011 3", m_valid, rr_ptr);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (m_valid !== 4'b0000 || rr_ptr !== 2'd0 ||
        {m_data_0, m_data_1, m_data_2, m_data_3} !== 32'h0) begin
      miscompares++; $display("FAIL ar_immediate: got m_valid=%b rr_ptr=%0d data=%h %h %h %h expected 0000 0 zeros",
                              m_valid, rr_ptr, m_data_0, m_data_1, m_data_2, m_data_3);
    end
    #1;
    rst = 1'b0;
    m_ready = 4'b1111;
    drive(1'b1, 1'b1, 2'd2, 8'hD0, 1'b0);
    tick();
    vectors++;
    if (m_valid !== 4'b0001 || m_data_0 !== 8'hD0) begin
      miscompares++; $display("FAIL ar_first_rr: got m_valid=%b m_data_0=%h expected 0001 d0", m_valid, m_data_0);
    end
    drive(1'b1, 1'b0, 2'd2, 8'hD1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    vectors++;
    if (m_valid !== 4'b0100 || m_data_2 !== 8'hD1 || rr_ptr !== 2'd1) begin
      miscompares++; $display("FAIL ar_first_sel: got m_valid=%b m_data_2=%h rr_ptr=%0d expected 0100 d1 1",
                              m_valid, m_data_2, rr_ptr);
    end
    tick();
  endtask

  initial begin
    rst     = 1'b1;
    m_ready = 4'b0000;
    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    test_reset();
    test_select();
    test_backpressure();
    test_round_robin();
    test_last();
    test_throughput();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
